fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational, word-indexed instruction memory. Owns the program counter and drives the memory's 32-bit pc input. Registers each returned instruction into a one-entry valid/ready output stage toward decode. Handles stall, branch redirect/flush, the halt sentinel 32'hFFFFFFFF and an out-of-range PC fault.

Parameters:
- MEM_DEPTH, 1000: number of valid instruction words; legal pc is 0..MEM_DEPTH-1.
- RESET_PC, 0: pc loaded on reset.
- HALT_WORD, 32'hFFFFFFFF: instruction value that stops fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- imem_pc  out  32  word index to instruction memory, zero-extended pc_q.
- imem_ins  in  32  combinational read data for imem_pc.
- out_valid  out  1  out_ins/out_pc hold a fetched instruction.
- out_ready  in  1  decode accepts when out_valid && out_ready.
- out_ins  out  32  fetched instruction.
- out_pc  out  32  pc of out_ins.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  target word index.
- halted  out  1  sticky; HALT_WORD fetched or fault.
- fault  out  1  sticky; pc out of range.
- fetch_count  out  32  accepted-instruction count (see Optional Feature).

Behaviour:
- States: IDLE, FETCH, HALTED. Reset (async, rst_n=0): state=IDLE, pc_q=RESET_PC, out_valid=0, out_ins=0, out_pc=0, halted=0, fault=0, fetch_count=0.
- imem_pc = pc_q at all times, combinationally.
- IDLE: start=1 -> FETCH next cycle. redirect_valid in IDLE loads pc_q=redirect_pc and stays IDLE.
- FETCH: the slot is free when !out_valid || out_ready.
  - Slot free, no redirect, imem_ins != HALT_WORD: capture out_ins=imem_ins, out_pc=pc_q, out_valid=1, pc_q=pc_q+1. Latency is 1 cycle from pc presentation to out_valid.
  - Slot free, imem_ins == HALT_WORD: do not capture. out_valid clears if the current entry is accepted. pc_q holds. state=HALTED, halted=1.
  - Slot not free (stall): out_*, pc_q and state all hold. out_ins/out_pc must not change while out_valid && !out_ready.
- Redirect in FETCH has the highest priority, including over stall and halt detection. pc_q=redirect_pc, out_valid=0 (flush, even if stalled), no capture that cycle, stay in FETCH.
- Range check: if pc_q >= MEM_DEPTH while in FETCH, or a redirect_pc >= MEM_DEPTH is taken, then next cycle state=HALTED, fault=1, halted=1, and no capture. A bad redirect sets fault immediately.
- HALTED: a pending out_valid entry still drains via out_ready. start, redirect_valid and fetch are ignored. Only rst_n exits.
- start while in FETCH or HALTED: ignored.
- Reset asserted mid-operation: every register returns to its reset value immediately. No partial handshake survives.
- pc arithmetic: 32-bit unsigned; the +1 never wraps because the range check stops fetch first.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on each out_valid && out_ready cycle and saturates at 32'hFFFFFFFF. Reset only by rst_n.
- Undefined: no counter logic is built; fetch_count is tied to 0.

Decomposition:
- fetch_pkg holds:
  - state enum {IDLE, FETCH, HALTED};
  - HALT_WORD constant;
  - NOP_WORD=32'h0.
- One sub-module is natural: fetch_out_reg, a one-entry valid/ready holding register with a flush input. fetch_ctrl instantiates it; the FSM and pc stay in fetch_ctrl.

Test Plan:
1. Memory loaded with words 0..5 = {0, 8D880000, 8D890001, 01095020, AD8A0002, FFFFFFFF}; out_ready=1; pulse start -> accepted out_pc sequence 0,1,2,3,4 with out_ins matching; then halted=1, fault=0, pc_q=5, HALT_WORD never appears on out_ins.
2. Same program, out_ready=0 for 3 cycles after the first capture -> out_ins=0, out_pc=0 stable for those cycles, pc_q=1. The sequence resumes with no loss or duplication.
3. Stall on out_pc=2 while redirect_valid=1, redirect_pc=4 -> next cycle out_valid=0. The following cycle captures out_pc=4, ins=AD8A0002.
4. redirect_pc=1000 with MEM_DEPTH=1000 -> fault=1, halted=1, and out_valid stays 0 after any pending entry drains.
5. rst_n low mid-stream (out_valid=1, pc_q=3) -> outputs go to reset values asynchronously. start is required again and fetch restarts from pc 0.
6. With FETCH_PERF_CNT_EN defined, run test 1 -> fetch_count=5. With it undefined -> fetch_count=0 throughout.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch sequencer: FSM encodings,
// sentinel instruction words and the pc range helper.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE   = 2'd0;
    localparam fetch_state_t ST_FETCH  = 2'd1;
    localparam fetch_state_t ST_HALTED = 2'd2;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    function automatic logic pc_in_range(input logic [31:0] pc, input logic [31:0] depth);
        return (pc < depth);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready holding register toward decode. A flush drops the
// entry; a load replaces it; otherwise an accepted entry is retired.
module fetch_out_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_ins,
    input  logic [31:0] load_pc,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] ins,
    output logic [31:0] pc
);
    import fetch_pkg::*;

    logic        valid_r;
    logic [31:0] ins_r;
    logic [31:0] pc_r;

    // Entry storage; payload only changes on load so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ins_r   <= NOP_WORD;
            pc_r    <= 32'd0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            ins_r   <= load_ins;
            pc_r    <= load_pc;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign ins   = ins_r;
    assign pc    = pc_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: pc, IDLE/FETCH/HALTED FSM, redirect, halt and
// range fault. Optional accepted-instruction counter under FETCH_PERF_CNT_EN.
module fetch_ctrl #(
    parameter int unsigned MEM_DEPTH = 1000,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_ins,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);
    import fetch_pkg::*;

    localparam logic [31:0] DEPTH_LIM = 32'(MEM_DEPTH);

    fetch_state_t state_r, state_nx_s;
    logic [31:0]  pc_r, pc_nx_s;
    logic         halted_r, halted_nx_s;
    logic         fault_r, fault_nx_s;
    logic         load_s, flush_s, slot_free_s;

    assign slot_free_s = !out_valid || out_ready;

    // Next-state logic; redirect outranks range check, stall and halt detection.
    always_comb begin
        state_nx_s  = state_r;
        pc_nx_s     = pc_r;
        halted_nx_s = halted_r;
        fault_nx_s  = fault_r;
        load_s      = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid && !pc_in_range(redirect_pc, DEPTH_LIM)) begin
                    state_nx_s  = ST_HALTED;
                    halted_nx_s = 1'b1;
                    fault_nx_s  = 1'b1;
                end else if (redirect_valid) begin
                    pc_nx_s    = redirect_pc;
                    state_nx_s = start ? ST_FETCH : ST_IDLE;
                end else if (start) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush_s = 1'b1;
                    if (!pc_in_range(redirect_pc, DEPTH_LIM)) begin
                        state_nx_s  = ST_HALTED;
                        halted_nx_s = 1'b1;
                        fault_nx_s  = 1'b1;
                    end else begin
                        pc_nx_s = redirect_pc;
                    end
                end else if (!pc_in_range(pc_r, DEPTH_LIM)) begin
                    state_nx_s  = ST_HALTED;
                    halted_nx_s = 1'b1;
                    fault_nx_s  = 1'b1;
                end else if (slot_free_s) begin
                    if (imem_ins == HALT_WORD) begin
                        state_nx_s  = ST_HALTED;
                        halted_nx_s = 1'b1;
                    end else begin
                        load_s  = 1'b1;
                        pc_nx_s = pc_r + 32'd1;
                    end
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_nx_s = ST_HALTED;
            end
            default: begin
                state_nx_s  = ST_HALTED;
                halted_nx_s = 1'b1;
                fault_nx_s  = 1'b1;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            pc_r     <= pc_nx_s;
            halted_r <= halted_nx_s;
            fault_r  <= fault_nx_s;
        end
    end

    fetch_out_reg u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_s),
        .load     (load_s),
        .load_ins (imem_ins),
        .load_pc  (pc_r),
        .ready    (out_ready),
        .valid    (out_valid),
        .ins      (out_ins),
        .pc       (out_pc)
    );

    assign imem_pc = pc_r;
    assign halted  = halted_r;
    assign fault   = fault_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;

    // Saturating count of instructions handed to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'd0;
        end else if (out_valid && out_ready && (fetch_count_r != 32'hFFFF_FFFF)) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: program run, stall, redirect, faults, reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_pc;
    logic [31:0] imem_ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] PROG [0:5] = '{32'h0000_0000, 32'h8D88_0000, 32'h8D89_0001,
                                           32'h0109_5020, 32'hAD8A_0002, 32'hFFFF_FFFF};
`ifdef FETCH_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd5;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    logic [31:0] mem [0:7];

    always #5 clk = ~clk;

    assign imem_ins = (imem_pc < 32'd8) ? mem[imem_pc[2:0]] : 32'h0000_0000;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_pc        (imem_pc),
        .imem_ins       (imem_ins),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut;
        rst_n          = 1'b0;
        start          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) mem[i] = PROG[i];
        mem[6] = 32'd0;
        mem[7] = 32'd0;
        rst_n          = 1'b0;
        start          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #2;
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_pc",     imem_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault",  32'(fault), 32'd0);
        chk("rst_count",  fetch_count, 32'd0);
        reset_dut();

        // Program run with decode always ready
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_first_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_pc",    out_pc, 32'(i));
            chk("t1_ins",   out_ins, PROG[i]);
        end
        tick();
        chk("t1_halt_valid", 32'(out_valid), 32'd0);
        chk("t1_halted",     32'(halted), 32'd1);
        chk("t1_fault",      32'(fault), 32'd0);
        chk("t1_pc_hold",    imem_pc, 32'd5);
        chk("t1_count",      fetch_count, EXP_CNT);
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1;
        tick();
        start          = 1'b0;
        redirect_valid = 1'b0;
        chk("t1_ign_pc",    imem_pc, 32'd5);
        chk("t1_ign_valid", 32'(out_valid), 32'd0);
        chk("t1_ign_halt",  32'(halted), 32'd1);

        // Stall for three cycles after the first capture
        reset_dut();
        chk("t2_count_rst", fetch_count, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t2_cap_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_st_valid", 32'(out_valid), 32'd1);
            chk("t2_st_pc",    out_pc, 32'd0);
            chk("t2_st_ins",   out_ins, 32'd0);
            chk("t2_st_ipc",   imem_pc, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("t2_res_pc1",  out_pc, 32'd1);
        chk("t2_res_ins1", out_ins, PROG[1]);
        tick();
        chk("t2_res_pc2",  out_pc, 32'd2);
        chk("t2_res_ins2", out_ins, PROG[2]);

        // Redirect while stalled on pc 2 flushes the entry
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("t3_flush_valid", 32'(out_valid), 32'd0);
        chk("t3_flush_ipc",   imem_pc, 32'd4);
        tick();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_pc",    out_pc, 32'd4);
        chk("t3_ins",   out_ins, PROG[4]);
        tick();
        chk("t3_halted", 32'(halted), 32'd1);
        chk("t3_drain",  32'(out_valid), 32'd0);

        // Out-of-range redirect faults immediately
        reset_dut();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1000;
        tick();
        redirect_valid = 1'b0;
        chk("t4_fault",  32'(fault), 32'd1);
        chk("t4_halted", 32'(halted), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t4_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd2;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t4_sticky", 32'(fault), 32'd1);
        chk("t4_valid2", 32'(out_valid), 32'd0);

        // Sequential fetch running off the end of memory
        reset_dut();
        start = 1'b1;
        tick();
        start          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd998;
        tick();
        redirect_valid = 1'b0;
        chk("tb_ipc",   imem_pc, 32'd998);
        chk("tb_fault0", 32'(fault), 32'd0);
        tick();
        chk("tb_pc998", out_pc, 32'd998);
        tick();
        chk("tb_pc999", out_pc, 32'd999);
        chk("tb_v999",  32'(out_valid), 32'd1);
        tick();
        chk("tb_fault",  32'(fault), 32'd1);
        chk("tb_halted", 32'(halted), 32'd1);
        chk("tb_valid",  32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        reset_dut();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        chk("t5_pre_ipc",   imem_pc, 32'd3);
        chk("t5_pre_ins",   out_ins, PROG[2]);
        rst_n = 1'b0;
        #2;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ins",   out_ins, 32'd0);
        chk("t5_pc",    out_pc, 32'd0);
        chk("t5_ipc",   imem_pc, 32'd0);
        chk("t5_count", fetch_count, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_idle_valid", 32'(out_valid), 32'd0);
        chk("t5_idle_ipc",   imem_pc, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_rs_valid", 32'(out_valid), 32'd1);
        chk("t5_rs_pc",    out_pc, 32'd0);

        // Redirect while idle loads pc without starting
        reset_dut();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd3;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("ti_ipc",   imem_pc, 32'd3);
        chk("ti_valid", 32'(out_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ti_pc",  out_pc, 32'd3);
        chk("ti_ins", out_ins, PROG[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
